running_minmax: RTL and testbench

Streaming min/max reduction unit: accepts one WIDTH-bit sample per cycle and tracks the running minimum or maximum over a frame of FRAME_LEN samples, together with the index of the winning sample. At frame end, or on early flush, it emits a one-cycle result pulse. It generalises the team's combinational 4-input min circuit to arbitrary width, frame length, signedness and min/max mode. It sits between a sample source (ADC/feature stream) and downstream threshold/peak logic.

---
 rtl/running_minmax.sv | 157 +++++++++++++++
 tb/tb_running_minmax.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/running_minmax.sv
// Streaming min/max reduction over frames of FRAME_LEN samples, reporting the
// winning sample, its index within the frame and the frame's sample count.
module running_minmax #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 16,
   parameter int SIGNED    = 0,
   localparam int IW       = $clog2(FRAME_LEN),
   localparam int CW       = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             mode,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_value,
   output logic [IW-1:0]    out_index,
   output logic [CW-1:0]    out_count,
   output logic             busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_LEN);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  best_reg, best_next;
   logic [IW-1:0]     best_idx_reg, best_idx_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic              mode_reg, mode_next;
   logic              out_valid_reg, out_valid_next;
   logic [WIDTH-1:0]  out_value_reg, out_value_next;
   logic [IW-1:0]     out_index_reg, out_index_next;
   logic [CW-1:0]     out_count_reg, out_count_next;

   logic              in_less;
   logic              in_greater;
   logic              in_better;
   logic [WIDTH-1:0]  sel_value;
   logic [IW-1:0]     sel_idx;
   logic [CW-1:0]     sel_cnt;
   logic              frame_done;

   // Signedness is fixed per instance, so only one comparator pair is built.
   generate
      if (SIGNED != 0) begin : g_signed_cmp
         assign in_less    = $signed(in_data) < $signed(best_reg);
         assign in_greater = $signed(in_data) > $signed(best_reg);
      end else begin : g_unsigned_cmp
         assign in_less    = in_data < best_reg;
         assign in_greater = in_data > best_reg;
      end
   endgenerate

   // Strict comparison so that ties keep the earliest sample.
   assign in_better = mode_reg ? in_greater : in_less;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         best_reg      <= '0;
         best_idx_reg  <= '0;
         cnt_reg       <= '0;
         mode_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         out_value_reg <= '0;
         out_index_reg <= '0;
         out_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         best_reg      <= best_next;
         best_idx_reg  <= best_idx_next;
         cnt_reg       <= cnt_next;
         mode_reg      <= mode_next;
         out_valid_reg <= out_valid_next;
         out_value_reg <= out_value_next;
         out_index_reg <= out_index_next;
         out_count_reg <= out_count_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      best_next      = best_reg;
      best_idx_next  = best_idx_reg;
      cnt_next       = cnt_reg;
      mode_next      = mode_reg;
      out_valid_next = 1'b0;
      out_value_next = out_value_reg;
      out_index_next = out_index_reg;
      out_count_next = out_count_reg;
      sel_value      = best_reg;
      sel_idx        = best_idx_reg;
      sel_cnt        = cnt_reg;
      frame_done     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               best_next     = in_data;
               best_idx_next = '0;
               cnt_next      = ONE_CNT;
               mode_next     = mode;
               if (flush) begin
                  // Single-sample frame completes immediately.
                  out_valid_next = 1'b1;
                  out_value_next = in_data;
                  out_index_next = '0;
                  out_count_next = ONE_CNT;
                  cnt_next       = '0;
               end else begin
                  state_next = ACCUM;
               end
            end
         end

         ACCUM: begin
            if (in_valid) begin
               sel_cnt = cnt_reg + ONE_CNT;
               if (in_better) begin
                  sel_value = in_data;
                  sel_idx   = cnt_reg[IW-1:0];
               end
            end
            best_next     = sel_value;
            best_idx_next = sel_idx;
            cnt_next      = sel_cnt;

            frame_done = flush || (in_valid && (sel_cnt == FULL_CNT));
            if (frame_done) begin
               out_valid_next = 1'b1;
               out_value_next = sel_value;
               out_index_next = sel_idx;
               out_count_next = sel_cnt;
               cnt_next       = '0;
               state_next     = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign out_valid = out_valid_reg;
   assign out_value = out_value_reg;
   assign out_index = out_index_reg;
   assign out_count = out_count_reg;
   assign busy      = (state_reg == ACCUM);

endmodule

// File: tb/tb_running_minmax.sv
// Directed bench for running_minmax: an unsigned and a signed instance share
// the same stimulus so both compare flavours are checked on every frame.
module tb_running_minmax;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       mode;
   logic       flush;

   logic       uv, sv;
   logic [7:0] uval, sval;
   logic [1:0] uidx, sidx;
   logic [2:0] ucnt, scnt;
   logic       ubusy, sbusy;

   int tests;
   int fails;

   // {valid, value, index, count}
   logic [13:0] res_u, res_s;
   assign res_u = {uv, uval, uidx, ucnt};
   assign res_s = {sv, sval, sidx, scnt};

   running_minmax #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(0)) u_uns (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .mode(mode), .flush(flush), .out_valid(uv), .out_value(uval),
      .out_index(uidx), .out_count(ucnt), .busy(ubusy)
   );

   running_minmax #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(1)) u_sgn (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .mode(mode), .flush(flush), .out_valid(sv), .out_value(sval),
      .out_index(sidx), .out_count(scnt), .busy(sbusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic m, input logic f);
      in_valid = v;
      in_data  = d;
      mode     = m;
      flush    = f;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      tests++;
      if ({res_u, ubusy} !== 15'h0) begin
         fails++;
         $display("FAIL reset_uns: got %h required %h", {res_u, ubusy}, 15'h0);
      end
      tests++;
      if ({res_s, sbusy} !== 15'h0) begin
         fails++;
         $display("FAIL reset_sgn: got %h required %h", {res_s, sbusy}, 15'h0);
      end
      $display("[TB] reset: outputs %h / %h", res_u, res_s);
   endtask

   task automatic test_unsigned_min();
      drive(1'b1, 8'd7, 1'b0, 1'b0);
      tests++;
      if (ubusy !== 1'b1) begin
         fails++;
         $display("FAIL umin_busy: got %b required 1", ubusy);
      end
      drive(1'b1, 8'd3, 1'b0, 1'b0);
      drive(1'b1, 8'd9, 1'b0, 1'b0);
      tests++;
      if (uv !== 1'b0) begin
         fails++;
         $display("FAIL umin_early_pulse: got %b required 0", uv);
      end
      drive(1'b1, 8'd5, 1'b0, 1'b0);
      tests++;
      if (res_u !== {1'b1, 8'd3, 2'd1, 3'd4}) begin
         fails++;
         $display("FAIL umin_result: got %h required %h", res_u, {1'b1, 8'd3, 2'd1, 3'd4});
      end
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      tests++;
      if ({res_u, ubusy} !== {1'b0, 8'd3, 2'd1, 3'd4, 1'b0}) begin
         fails++;
         $display("FAIL umin_hold: got %h required %h", {res_u, ubusy}, {1'b0, 8'd3, 2'd1, 3'd4, 1'b0});
      end
      $display("[TB] unsigned min 7,3,9,5: value=%0d index=%0d count=%0d", uval, uidx, ucnt);
   endtask

   task automatic test_ties_max();
      drive(1'b1, 8'd5, 1'b1, 1'b0);
      drive(1'b1, 8'd9, 1'b0, 1'b0);
      drive(1'b1, 8'd9, 1'b0, 1'b0);
      drive(1'b1, 8'd2, 1'b0, 1'b0);
      tests++;
      if (res_u !== {1'b1, 8'd9, 2'd1, 3'd4}) begin
         fails++;
         $display("FAIL max_tie: got %h required %h", res_u, {1'b1, 8'd9, 2'd1, 3'd4});
      end
      $display("[TB] max 5,9,9,2: value=%0d index=%0d", uval, uidx);
      for (int i = 0; i < 4; i++) drive(1'b1, 8'd4, 1'b0, 1'b0);
      tests++;
      if (res_u !== {1'b1, 8'd4, 2'd0, 3'd4}) begin
         fails++;
         $display("FAIL min_all_equal: got %h required %h", res_u, {1'b1, 8'd4, 2'd0, 3'd4});
      end
      $display("[TB] min 4,4,4,4: value=%0d index=%0d", uval, uidx);
      drive(1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic test_signed();
      drive(1'b1, 8'h05, 1'b0, 1'b0);
      drive(1'b1, 8'hFE, 1'b0, 1'b0);
      drive(1'b1, 8'h80, 1'b0, 1'b0);
      drive(1'b1, 8'h7F, 1'b0, 1'b0);
      tests++;
      if (res_s !== {1'b1, 8'h80, 2'd2, 3'd4}) begin
         fails++;
         $display("FAIL signed_min: got %h required %h", res_s, {1'b1, 8'h80, 2'd2, 3'd4});
      end
      tests++;
      if (res_u !== {1'b1, 8'h05, 2'd0, 3'd4}) begin
         fails++;
         $display("FAIL unsigned_same_samples: got %h required %h", res_u, {1'b1, 8'h05, 2'd0, 3'd4});
      end
      $display("[TB] signed min: sgn=%h@%0d uns=%h@%0d", sval, sidx, uval, uidx);
      drive(1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic test_flush();
      drive(1'b1, 8'd6, 1'b0, 1'b0);
      drive(1'b1, 8'd2, 1'b0, 1'b0);
      drive(1'b1, 8'd1, 1'b0, 1'b1);
      tests++;
      if (res_u !== {1'b1, 8'd1, 2'd2, 3'd3}) begin
         fails++;
         $display("FAIL flush_early: got %h required %h", res_u, {1'b1, 8'd1, 2'd2, 3'd3});
      end
      $display("[TB] flush after 6,2,+1: value=%0d index=%0d count=%0d", uval, uidx, ucnt);
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 8'hAA, 1'b0, 1'b1);
      tests++;
      if ({res_u, ubusy} !== {1'b1, 8'hAA, 2'd0, 3'd1, 1'b0}) begin
         fails++;
         $display("FAIL flush_single: got %h required %h", {res_u, ubusy}, {1'b1, 8'hAA, 2'd0, 3'd1, 1'b0});
      end
      tests++;
      if (res_s !== {1'b1, 8'hAA, 2'd0, 3'd1}) begin
         fails++;
         $display("FAIL flush_single_sgn: got %h required %h", res_s, {1'b1, 8'hAA, 2'd0, 3'd1});
      end
      $display("[TB] single-sample flush: value=%h count=%0d", uval, ucnt);
      drive(1'b0, 8'h55, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tests++;
      if ({res_u, ubusy} !== {1'b0, 8'hAA, 2'd0, 3'd1, 1'b0}) begin
         fails++;
         $display("FAIL flush_idle_ignored: got %h required %h", {res_u, ubusy}, {1'b0, 8'hAA, 2'd0, 3'd1, 1'b0});
      end
      $display("[TB] idle flush: out_valid=%b", uv);
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [8];
      logic       m [8];
      logic       exp_v;
      d = '{8'd10, 8'd20, 8'd5, 8'd5, 8'd3, 8'd90, 8'd1, 8'd90};
      m = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, d[i], m[i], 1'b0);
         exp_v = (i == 3) || (i == 7);
         tests++;
         if (uv !== exp_v) begin
            fails++;
            $display("FAIL b2b_pulse_%0d: got %b required %b", i, uv, exp_v);
         end
         if (i == 3) begin
            tests++;
            if ({res_u, ubusy} !== {1'b1, 8'd5, 2'd2, 3'd4, 1'b0}) begin
               fails++;
               $display("FAIL b2b_frame1: got %h required %h", {res_u, ubusy}, {1'b1, 8'd5, 2'd2, 3'd4, 1'b0});
            end
            $display("[TB] b2b frame1 (min): value=%0d index=%0d", uval, uidx);
         end
         if (i == 4) begin
            tests++;
            if (ubusy !== 1'b1) begin
               fails++;
               $display("FAIL b2b_busy: got %b required 1", ubusy);
            end
         end
         if (i == 7) begin
            tests++;
            if (res_u !== {1'b1, 8'd90, 2'd1, 3'd4}) begin
               fails++;
               $display("FAIL b2b_frame2: got %h required %h", res_u, {1'b1, 8'd90, 2'd1, 3'd4});
            end
            tests++;
            if (res_s !== {1'b1, 8'd90, 2'd1, 3'd4}) begin
               fails++;
               $display("FAIL b2b_frame2_sgn: got %h required %h", res_s, {1'b1, 8'd90, 2'd1, 3'd4});
            end
            $display("[TB] b2b frame2 (max): value=%0d index=%0d", uval, uidx);
         end
      end
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      tests++;
      if (uv !== 1'b0) begin
         fails++;
         $display("FAIL b2b_tail: got %b required 0", uv);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 8'd1, 1'b0, 1'b0);
      drive(1'b1, 8'd2, 1'b0, 1'b0);
      reset = 1'b1;
      drive(1'b1, 8'd0, 1'b1, 1'b1);
      reset = 1'b0;
      tests++;
      if ({res_u, ubusy} !== 15'h0) begin
         fails++;
         $display("FAIL reset_mid_outputs: got %h required %h", {res_u, ubusy}, 15'h0);
      end
      tests++;
      if ({res_s, sbusy} !== 15'h0) begin
         fails++;
         $display("FAIL reset_mid_outputs_sgn: got %h required %h", {res_s, sbusy}, 15'h0);
      end
      drive(1'b1, 8'd8, 1'b0, 1'b0);
      drive(1'b1, 8'd6, 1'b0, 1'b0);
      drive(1'b1, 8'd7, 1'b0, 1'b0);
      tests++;
      if (uv !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_early: got %b required 0", uv);
      end
      drive(1'b1, 8'd9, 1'b0, 1'b0);
      tests++;
      if (res_u !== {1'b1, 8'd6, 2'd1, 3'd4}) begin
         fails++;
         $display("FAIL reset_mid_result: got %h required %h", res_u, {1'b1, 8'd6, 2'd1, 3'd4});
      end
      $display("[TB] post-reset frame 8,6,7,9: value=%0d index=%0d count=%0d", uval, uidx, ucnt);
      drive(1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      mode     = 1'b0;
      flush    = 1'b0;
      test_reset();
      test_unsigned_min();
      test_ties_max();
      test_signed();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
